mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single PDP8 memory controller port between two requesters: the instruction fetch unit (read only) and the execute unit (data read or write).
- Sits between the CPU front end and memory_controller.
- Serialises accesses, drives the controller's enable/read_type/address/data pins, and waits for operation_done.
- Returns data plus a one-cycle done pulse to the owning requester, with a watchdog timeout.

Parameters:
- WORD_W, 12, width of address and data words (PDP8 word).
- TIMEOUT, 15, max cycles spent in WAIT before the access is aborted with err; legal range 3..255.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  WORD_W  fetch address
- if_rdata  out  WORD_W  fetched instruction, valid when if_done=1
- if_done  out  1  one-cycle completion pulse to fetch
- ex_req  in  1  execute request, level, held until ex_done
- ex_we  in  1  1=write, 0=data read
- ex_addr  in  WORD_W  execute address
- ex_wdata  in  WORD_W  write data
- ex_rdata  out  WORD_W  read data, valid when ex_done=1
- ex_done  out  1  one-cycle completion pulse to execute
- err  out  1  pulses with if_done/ex_done when the access timed out
- mem_address  out  WORD_W  to controller address
- mem_write_data  out  WORD_W  to controller write_data
- mem_read_enable  out  1  to controller read_enable
- mem_read_type  out  1  to controller read_type
- mem_write_enable  out  1  to controller write_enable
- mem_read_data  in  WORD_W  from controller read_data
- mem_operation_done  in  1  from controller operation_done

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, timeout counter 0, round-robin pointer = fetch-favoured.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples if_req/ex_req.
  - No request: stays IDLE.
  - Otherwise selects a winner, latches owner, address, we, wdata and read_type (`INSTRUCTION_FETCH for fetch, `DATA_READ for execute reads), then goes to ISSUE.
- ISSUE (exactly one cycle):
  - mem_write_enable=1 for an execute write, else mem_read_enable=1.
  - mem_address, mem_write_data and mem_read_type are driven from the latch.
  - Goes to WAIT.
- WAIT:
  - Enables are 0; address/data/read_type are held stable.
  - Timeout counter increments each cycle.
  - On mem_operation_done=1: capture mem_read_data (writes capture 0), go to RESP.
  - If the counter reaches TIMEOUT first: captured data=0, set the err flag, go to RESP.
- RESP:
  - Owner's done=1 and its rdata are driven for exactly one cycle; err=1 only if timed out.
  - The other requester's done/rdata stay 0.
  - Goes to IDLE; mem_* address/data return to 0.
- Latency: request seen in IDLE at cycle 0 -> done pulse at cycle 4 with the standard controller (ISSUE c1, WAIT c2-c3, RESP c4).
- Throughput: one access per 5 cycles back-to-back.
- Arbitration without the macro: fixed priority, execute wins over fetch on a simultaneous request.
- Handshake rules:
  - A requester holds req and its payload stable until its done.
  - It must deassert req the cycle after done unless it issues a new request.
  - Payload changes while its access is in flight are ignored because the payload is latched.
- mem_operation_done is ignored in IDLE, ISSUE and RESP (stray pulses are not attributed).
- Reset mid-operation: aborts immediately, no done pulse; the controller may still complete the access, and the resulting operation_done arrives outside WAIT and is ignored.
- A request dropped before done is not cancelled; the access still completes and done still pulses.

Optional Feature:
- Macro MEM_ARB_ROUND_ROBIN_EN.
- Defined: on a simultaneous request, grant the requester not granted last. The pointer updates on every grant and resets fetch-favoured.
- Undefined: fixed execute-over-fetch priority; no pointer register exists.
- Single requests behave identically in both builds.

Test Plan:
- Fetch only: if_req=1, if_addr=0200, memory[0200]=7402 -> mem_read_enable high only in cycle 1 with mem_read_type=`INSTRUCTION_FETCH; if_done=1, if_rdata=7402 at cycle 4; ex_done stays 0.
- Execute write then read: ex_we=1, ex_addr=0050, ex_wdata=1234 -> mem_write_enable one cycle, ex_done at cycle 4 with ex_rdata=0; then ex_we=0, ex_addr=0050 -> ex_rdata=1234, mem_read_type=`DATA_READ.
- Contention: if_req and ex_req both rise in the same cycle. Default build: execute done at cycle 4, fetch done at cycle 9. MEM_ARB_ROUND_ROBIN_EN build, two back-to-back contended pairs: grant order ex, if, ex, if.
- Timeout: mem_operation_done tied 0, ex_req read -> ex_done=1 and err=1 exactly TIMEOUT cycles after WAIT entry, ex_rdata=0, FSM back to IDLE.
- Reset mid-WAIT: reset_n low during WAIT of a fetch -> all outputs 0 asynchronously; the late mem_operation_done after release produces no if_done.
- Stray done: pulse mem_operation_done while IDLE with no request -> no done pulse, no state change.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single PDP8 memory controller port between the
// instruction fetch unit (read only) and the execute unit (read/write).
// One access at a time: IDLE -> ISSUE -> WAIT -> RESP, with a WAIT watchdog.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: round-robin grant on a
// simultaneous request instead of fixed execute-over-fetch priority.

`ifndef INSTRUCTION_FETCH
`define INSTRUCTION_FETCH 1'b1
`endif
`ifndef DATA_READ
`define DATA_READ 1'b0
`endif

module mem_arbiter #(
   parameter int unsigned WORD_W  = 12,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              if_req,
   input  logic [WORD_W-1:0] if_addr,
   output logic [WORD_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              ex_req,
   input  logic              ex_we,
   input  logic [WORD_W-1:0] ex_addr,
   input  logic [WORD_W-1:0] ex_wdata,
   output logic [WORD_W-1:0] ex_rdata,
   output logic              ex_done,
   output logic              err,
   output logic [WORD_W-1:0] mem_address,
   output logic [WORD_W-1:0] mem_write_data,
   output logic              mem_read_enable,
   output logic              mem_read_type,
   output logic              mem_write_enable,
   input  logic [WORD_W-1:0] mem_read_data,
   input  logic              mem_operation_done
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t              r_state, w_state;
   logic [CNT_W-1:0]    r_cnt, w_cnt;
   logic                r_owner_ex, w_owner_ex;
   logic                r_we, w_we;
   logic [WORD_W-1:0]   r_if_rdata, w_if_rdata;
   logic                r_if_done, w_if_done;
   logic [WORD_W-1:0]   r_ex_rdata, w_ex_rdata;
   logic                r_ex_done, w_ex_done;
   logic                r_err, w_err;
   logic [WORD_W-1:0]   r_mem_address, w_mem_address;
   logic [WORD_W-1:0]   r_mem_write_data, w_mem_write_data;
   logic                r_mem_read_enable, w_mem_read_enable;
   logic                r_mem_read_type, w_mem_read_type;
   logic                r_mem_write_enable, w_mem_write_enable;
   logic                w_grant_ex;
   logic [WORD_W-1:0]   w_resp_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // 1 = fetch was granted last, so execute wins the next tie
   logic                r_last_if, w_last_if;

   // Tie goes to whoever was not granted last
   always_comb begin
      w_grant_ex = ex_req && (!if_req || r_last_if);
   end
`else
   // Fixed priority: execute beats fetch on a tie
   always_comb begin
      w_grant_ex = ex_req;
   end
`endif

   // Next-state and next-output logic; every output register is loaded from here
   always_comb begin
      w_state            = r_state;
      w_cnt              = r_cnt;
      w_owner_ex         = r_owner_ex;
      w_we               = r_we;
      w_if_rdata         = '0;
      w_if_done          = 1'b0;
      w_ex_rdata         = '0;
      w_ex_done          = 1'b0;
      w_err              = 1'b0;
      w_mem_address      = r_mem_address;
      w_mem_write_data   = r_mem_write_data;
      w_mem_read_enable  = 1'b0;
      w_mem_read_type    = r_mem_read_type;
      w_mem_write_enable = 1'b0;
      w_resp_data        = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      w_last_if          = r_last_if;
`endif
      case (r_state)
         S_IDLE: begin
            if (if_req || ex_req) begin
               w_owner_ex         = w_grant_ex;
               w_we               = w_grant_ex && ex_we;
               w_mem_address      = w_grant_ex ? ex_addr : if_addr;
               w_mem_write_data   = (w_grant_ex && ex_we) ? ex_wdata : '0;
               w_mem_read_type    = w_grant_ex ? `DATA_READ : `INSTRUCTION_FETCH;
               w_mem_write_enable = w_grant_ex && ex_we;
               w_mem_read_enable  = !(w_grant_ex && ex_we);
               w_cnt              = '0;
               w_state            = S_ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
               w_last_if          = !w_grant_ex;
`endif
            end
         end
         S_ISSUE: begin
            w_cnt   = '0;
            w_state = S_WAIT;
         end
         S_WAIT: begin
            if (mem_operation_done || (r_cnt == CNT_W'(TIMEOUT - 1))) begin
               // Writes and timed-out accesses return zero data
               w_resp_data = (mem_operation_done && !r_we) ? mem_read_data : '0;
               w_err       = !mem_operation_done;
               w_if_done   = !r_owner_ex;
               w_ex_done   = r_owner_ex;
               w_if_rdata  = r_owner_ex ? '0 : w_resp_data;
               w_ex_rdata  = r_owner_ex ? w_resp_data : '0;
               w_state     = S_RESP;
            end else begin
               w_cnt = r_cnt + CNT_W'(1);
            end
         end
         S_RESP: begin
            w_mem_address    = '0;
            w_mem_write_data = '0;
            w_mem_read_type  = 1'b0;
            w_cnt            = '0;
            w_state          = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   // State, latch and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state            <= S_IDLE;
         r_cnt              <= '0;
         r_owner_ex         <= 1'b0;
         r_we               <= 1'b0;
         r_if_rdata         <= '0;
         r_if_done          <= 1'b0;
         r_ex_rdata         <= '0;
         r_ex_done          <= 1'b0;
         r_err              <= 1'b0;
         r_mem_address      <= '0;
         r_mem_write_data   <= '0;
         r_mem_read_enable  <= 1'b0;
         r_mem_read_type    <= 1'b0;
         r_mem_write_enable <= 1'b0;
      end else begin
         r_state            <= w_state;
         r_cnt              <= w_cnt;
         r_owner_ex         <= w_owner_ex;
         r_we               <= w_we;
         r_if_rdata         <= w_if_rdata;
         r_if_done          <= w_if_done;
         r_ex_rdata         <= w_ex_rdata;
         r_ex_done          <= w_ex_done;
         r_err              <= w_err;
         r_mem_address      <= w_mem_address;
         r_mem_write_data   <= w_mem_write_data;
         r_mem_read_enable  <= w_mem_read_enable;
         r_mem_read_type    <= w_mem_read_type;
         r_mem_write_enable <= w_mem_write_enable;
      end
   end

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Round-robin pointer, fetch counted as last granted out of reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last_if <= 1'b1;
      end else begin
         r_last_if <= w_last_if;
      end
   end
`endif

   assign if_rdata         = r_if_rdata;
   assign if_done          = r_if_done;
   assign ex_rdata         = r_ex_rdata;
   assign ex_done          = r_ex_done;
   assign err              = r_err;
   assign mem_address      = r_mem_address;
   assign mem_write_data   = r_mem_write_data;
   assign mem_read_enable  = r_mem_read_enable;
   assign mem_read_type    = r_mem_read_type;
   assign mem_write_enable = r_mem_write_enable;

endmodule
